// File: rtl/dmem_arbiter_if.sv
// Host burst port of the data-memory arbiter: preload (write-in) and readback (read-out).
// master = host side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          host_go;
  logic          host_wr;
  logic [AW-1:0] host_base;
  logic [AW-1:0] host_len;
  logic [DW-1:0] host_wdata;
  logic          host_wvalid;
  logic          host_wready;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          host_busy;
  logic          host_done;

  modport master (
    output host_go, host_wr, host_base, host_len, host_wdata, host_wvalid,
    input  host_wready, host_rdata, host_rvalid, host_busy, host_done
  );

  modport slave (
    input  host_go, host_wr, host_base, host_len, host_wdata, host_wvalid,
    output host_wready, host_rdata, host_rvalid, host_busy, host_done
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core (default owner, zero latency)
// and the host burst port, which gets the memory after a bounded wait and keeps it until done.
module dmem_arbiter #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned STARVE = 4
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  dmem_arbiter_if.slave host,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WCW = (STARVE > 1) ? $clog2(STARVE) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]     state_q,    state_d;
  logic           wr_q,       wr_d;
  logic [AW-1:0]  base_q,     base_d;
  logic [AW-1:0]  len_q,      len_d;
  logic [AW-1:0]  idx_q,      idx_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]  rdata_q,    rdata_d;
  logic           rvalid_q,   rvalid_d;
  logic           done_q,     done_d;
  logic           busy_q,     busy_d;
  logic           wready_q,   wready_d;

  logic in_burst;
  logic beat_wr;
  logic beat_rd;

  assign in_burst = (state_q == ST_BURST);
  assign beat_wr  = in_burst && wr_q && host.host_wvalid;
  assign beat_rd  = in_burst && !wr_q;

  // Next state, burst bookkeeping and memory-port steering.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;

    mem_addr   = cpu_addr;
    mem_we     = cpu_req && cpu_we;
    mem_wdata  = cpu_wdata;
    cpu_stall  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.host_go) begin
          wr_d       = host.host_wr;
          base_d     = host.host_base;
          len_d      = host.host_len;
          idx_d      = '0;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!cpu_req || (wait_cnt_q == WCW'(STARVE - 1))) begin
          state_d = ST_BURST;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_BURST: begin
        mem_addr  = base_q + idx_q;
        mem_we    = beat_wr;
        mem_wdata = host.host_wdata;
        cpu_stall = cpu_req;
        if (beat_rd) begin
          rdata_d  = mem_rdata;
          rvalid_d = 1'b1;
        end
        if (beat_wr || beat_rd) begin
          if (idx_q == len_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Nothing is written into memory while the system is held in reset.
    if (!reset_n) begin
      mem_we = 1'b0;
    end

    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    wready_d = (state_d == ST_BURST) && wr_d;
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wready_q   <= wready_d;
    end
  end

  assign cpu_rdata        = mem_rdata;
  assign host.host_rdata  = rdata_q;
  assign host.host_rvalid = rvalid_q;
  assign host.host_done   = done_q;
  assign host.host_busy   = busy_q;
  assign host.host_wready = wready_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 async-read memory.
module tb_dmem_arbiter;

  logic       clk;
  logic       reset_n;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_clr;
  logic [7:0] mem [256];

  int n_cmp;
  int n_err;

  dmem_arbiter_if #(.AW(8), .DW(8)) hif ();

  dmem_arbiter #(.AW(8), .DW(8), .STARVE(4)) dut (
    .CLK       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .host      (hif),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; clear loads 0x11,0x22,0x33,0x44 at addresses 5..8, zero elsewhere.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i >= 5 && i <= 8) ? 8'(8'h11 * (i - 4)) : 8'h00;
      end
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Four-beat write burst, no wvalid gaps, core idle.
  task automatic wr4(input string tag, input logic [7:0] base, input logic [31:0] bytes);
    hif.host_go = 1'b1; hif.host_wr = 1'b1; hif.host_base = base; hif.host_len = 8'd3;
    hif.host_wvalid = 1'b1; hif.host_wdata = bytes[31:24];
    #1 chk({tag, "_idle_we"}, 32'(mem_we), 0);
    cyc();
    hif.host_go = 1'b0;
    #1 chk({tag, "_wait_busy"}, 32'(hif.host_busy), 1);
    chk({tag, "_wait_wready"}, 32'(hif.host_wready), 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      hif.host_wdata = bytes[31 - 8 * k -: 8];
      #1 chk({tag, "_beat_we"}, 32'(mem_we), 1);
      chk({tag, "_beat_addr"}, 32'(mem_addr), 32'(8'(base + 8'(k))));
      chk({tag, "_beat_wdata"}, 32'(mem_wdata), 32'(bytes[31 - 8 * k -: 8]));
      chk({tag, "_beat_wready"}, 32'(hif.host_wready), 1);
      chk({tag, "_beat_done"}, 32'(hif.host_done), 0);
      cyc();
    end
    hif.host_wvalid = 1'b0;
    #1 chk({tag, "_done"}, 32'(hif.host_done), 1);
    chk({tag, "_done_wready"}, 32'(hif.host_wready), 0);
    chk({tag, "_done_we"}, 32'(mem_we), 0);
    cyc();
    #1 chk({tag, "_post_done"}, 32'(hif.host_done), 0);
    chk({tag, "_post_busy"}, 32'(hif.host_busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    mem_clr = 1'b1;
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    hif.host_go = 1'b1; hif.host_wr = 1'b1; hif.host_base = 8'h40; hif.host_len = 8'd3;
    hif.host_wdata = 8'h00; hif.host_wvalid = 1'b0;

    // Reset with host_go held high
    cyc(); cyc();
    chk("rst_busy",   32'(hif.host_busy), 0);
    chk("rst_done",   32'(hif.host_done), 0);
    chk("rst_rvalid", 32'(hif.host_rvalid), 0);
    chk("rst_rdata",  32'(hif.host_rdata), 0);
    chk("rst_wready", 32'(hif.host_wready), 0);
    chk("rst_stall",  32'(cpu_stall), 0);
    chk("rst_we",     32'(mem_we), 0);
    reset_n = 1'b1; hif.host_go = 1'b0; mem_clr = 1'b0;
    cyc();
    chk("rel_busy", 32'(hif.host_busy), 0);

    // Write preload at 0x00
    wr4("pre", 8'h00, 32'h0555_07FF);
    chk("pre_m0", 32'(mem[0]), 32'h05);
    chk("pre_m1", 32'(mem[1]), 32'h55);
    chk("pre_m2", 32'(mem[2]), 32'h07);
    chk("pre_m3", 32'(mem[3]), 32'hFF);

    // Wrap at 0xFF with a two-cycle wvalid gap
    hif.host_go = 1'b1; hif.host_wr = 1'b1; hif.host_base = 8'hFE; hif.host_len = 8'd2;
    hif.host_wvalid = 1'b1; hif.host_wdata = 8'hAA;
    cyc();
    hif.host_go = 1'b0;
    cyc();
    #1 chk("wrap_a_addr", 32'(mem_addr), 32'hFE);
    chk("wrap_a_we", 32'(mem_we), 1);
    cyc();
    hif.host_wvalid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      #1 chk("gap_we", 32'(mem_we), 0);
      chk("gap_addr", 32'(mem_addr), 32'hFF);
      cyc();
    end
    hif.host_wvalid = 1'b1; hif.host_wdata = 8'hBB;
    #1 chk("wrap_b_addr", 32'(mem_addr), 32'hFF);
    chk("wrap_b_we", 32'(mem_we), 1);
    cyc();
    hif.host_wdata = 8'hCC;
    #1 chk("wrap_c_addr", 32'(mem_addr), 32'h00);
    cyc();
    hif.host_wvalid = 1'b0;
    #1 chk("wrap_done", 32'(hif.host_done), 1);
    cyc();
    chk("wrap_mFE", 32'(mem[8'hFE]), 32'hAA);
    chk("wrap_mFF", 32'(mem[8'hFF]), 32'hBB);
    chk("wrap_m00", 32'(mem[8'h00]), 32'hCC);

    // Contention: core busy throughout, STARVE=4
    hif.host_go = 1'b1; hif.host_wr = 1'b1; hif.host_base = 8'h20; hif.host_len = 8'd1;
    hif.host_wvalid = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    #1 chk("ct_idle_stall", 32'(cpu_stall), 0);
    cyc();
    hif.host_go = 1'b0;
    cpu_we = 1'b1; cpu_wdata = 8'h77;
    #1 chk("ct_wait_stall", 32'(cpu_stall), 0);
    chk("ct_wait_we", 32'(mem_we), 1);
    chk("ct_wait_addr", 32'(mem_addr), 32'h10);
    cyc();
    cpu_we = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1 chk("ct_wait_stall", 32'(cpu_stall), 0);
      chk("ct_wait_load", 32'(cpu_rdata), 32'h77);
      chk("ct_wait_busy", 32'(hif.host_busy), 1);
      cyc();
    end
    cpu_we = 1'b1; cpu_wdata = 8'h99;
    hif.host_wvalid = 1'b1; hif.host_wdata = 8'h31;
    #1 chk("ct_b0_stall", 32'(cpu_stall), 1);
    chk("ct_b0_addr", 32'(mem_addr), 32'h20);
    chk("ct_b0_wdata", 32'(mem_wdata), 32'h31);
    chk("ct_b0_we", 32'(mem_we), 1);
    cyc();
    hif.host_wvalid = 1'b0;
    #1 chk("ct_gap_stall", 32'(cpu_stall), 1);
    chk("ct_gap_we", 32'(mem_we), 0);
    cyc();
    hif.host_wvalid = 1'b1; hif.host_wdata = 8'h32;
    #1 chk("ct_b1_stall", 32'(cpu_stall), 1);
    chk("ct_b1_addr", 32'(mem_addr), 32'h21);
    cyc();
    hif.host_wvalid = 1'b0;
    #1 chk("ct_done", 32'(hif.host_done), 1);
    chk("ct_done_stall", 32'(cpu_stall), 0);
    chk("ct_done_we", 32'(mem_we), 1);
    chk("ct_done_addr", 32'(mem_addr), 32'h10);
    chk("ct_done_wdata", 32'(mem_wdata), 32'h99);
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("ct_m10", 32'(mem[8'h10]), 32'h99);
    chk("ct_m20", 32'(mem[8'h20]), 32'h31);
    chk("ct_m21", 32'(mem[8'h21]), 32'h32);

    // Read readback of preloaded 5..8
    hif.host_go = 1'b1; hif.host_wr = 1'b0; hif.host_base = 8'h05; hif.host_len = 8'd3;
    cyc();
    hif.host_go = 1'b0;
    #1 chk("rd_wait_rvalid", 32'(hif.host_rvalid), 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1 chk("rd_addr", 32'(mem_addr), 32'(8'h05 + 8'(k)));
      chk("rd_we", 32'(mem_we), 0);
      chk("rd_rvalid", 32'(hif.host_rvalid), (k == 0) ? 0 : 1);
      if (k > 0) chk("rd_rdata", 32'(hif.host_rdata), 32'(8'h11 * k));
      chk("rd_done_early", 32'(hif.host_done), 0);
      cyc();
    end
    #1 chk("rd_last_rvalid", 32'(hif.host_rvalid), 1);
    chk("rd_last_rdata", 32'(hif.host_rdata), 32'h44);
    chk("rd_done", 32'(hif.host_done), 1);
    cyc();
    #1 chk("rd_post_rvalid", 32'(hif.host_rvalid), 0);

    // Abort after 2 of 4 write beats
    hif.host_go = 1'b1; hif.host_wr = 1'b1; hif.host_base = 8'h30; hif.host_len = 8'd3;
    hif.host_wvalid = 1'b1; hif.host_wdata = 8'hD1;
    cyc();
    hif.host_go = 1'b0;
    cyc();
    cyc();
    hif.host_wdata = 8'hD2;
    cyc();
    hif.host_wdata = 8'hD3; reset_n = 1'b0;
    #1 chk("ab_rst_we", 32'(mem_we), 0);
    cyc();
    reset_n = 1'b1; hif.host_wvalid = 1'b0;
    #1 chk("ab_busy", 32'(hif.host_busy), 0);
    chk("ab_done", 32'(hif.host_done), 0);
    chk("ab_wready", 32'(hif.host_wready), 0);
    cyc();
    #1 chk("ab_done2", 32'(hif.host_done), 0);
    chk("ab_m30", 32'(mem[8'h30]), 32'hD1);
    chk("ab_m31", 32'(mem[8'h31]), 32'hD2);
    chk("ab_m32", 32'(mem[8'h32]), 32'h00);
    chk("ab_m33", 32'(mem[8'h33]), 32'h00);

    wr4("re", 8'h30, 32'hE1E2_E3E4);
    chk("re_m30", 32'(mem[8'h30]), 32'hE1);
    chk("re_m31", 32'(mem[8'h31]), 32'hE2);
    chk("re_m32", 32'(mem[8'h32]), 32'hE3);
    chk("re_m33", 32'(mem[8'h33]), 32'hE4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 256×8 data memory between the processor core and a host burst port used for program-data preload and result readback. The core owns the memory by default with zero added latency. A host burst (write-in or read-out) is granted after a bounded wait and holds the memory until done, stalling the core. It sits between the TopLevel datapath and the data memory instance.

## Interface
- AW, 8, address width; memory depth 2^AW
- DW, 8, data width
- STARVE, 4, max cycles a pending host burst waits on a busy core (≥1)

- CLK  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  core memory access this cycle
- cpu_we  in  1  core access is a store
- cpu_addr  in  AW  core address
- cpu_wdata  in  DW  core store data
- cpu_rdata  out  DW  core load data (combinational from mem_rdata)
- cpu_stall  out  1  core access not performed this cycle; core must hold request
- host_go  in  1  pulse; start burst (sampled only in IDLE)
- host_wr  in  1  1 = write burst into memory, 0 = read burst out
- host_base  in  AW  burst start address
- host_len  in  AW  beats minus one (0..255 → 1..256 bytes)
- host_wdata  in  DW  write beat data
- host_wvalid  in  1  write beat offered
- host_wready  out  1  write beat accepted this cycle
- host_rdata  out  DW  read beat data (registered)
- host_rvalid  out  1  host_rdata valid
- host_busy  out  1  state ≠ IDLE
- host_done  out  1  one-cycle pulse, burst complete
- mem_addr  out  AW  to data memory
- mem_we  out  1  to data memory
- mem_wdata  out  DW  to data memory
- mem_rdata  in  DW  from data memory, asynchronous read

## Operation
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE: host_go=1 → latch host_wr, host_base, host_len; clear idx and wait_cnt; → WAIT. host_go ignored in all other states.
- WAIT: cpu_req=0 or wait_cnt==STARVE-1 → BURST; else wait_cnt++. With the core continuously busy, WAIT lasts exactly STARVE cycles. With the core idle, WAIT lasts 1 cycle.
- Core grant (IDLE, WAIT, DONE):
  - mem_addr=cpu_addr, mem_we=cpu_req&cpu_we, mem_wdata=cpu_wdata.
  - cpu_stall=0.
- BURST:
  - Host owns memory; cpu_stall=cpu_req; core stores never reach mem_we.
  - mem_addr = (base+idx) mod 2^AW, wrapping 0xFF→0x00.
  - Write burst: host_wready=1. A beat occurs when host_wvalid=1: mem_we=1, mem_wdata=host_wdata, idx++. When host_wvalid=0: mem_we=0 and idx holds. No beat limit per stall.
  - Read burst: one beat every cycle, no backpressure. host_rdata<=mem_rdata and host_rvalid<=1 on the next edge.
  - Final beat (idx==len) → DONE.
- DONE: host_done=1 for one cycle → IDLE. The core is granted in this cycle.
- cpu_rdata=mem_rdata always. It is meaningful only when cpu_stall=0.

## Timing
- Reset (reset_n=0 at an edge):
  - State → IDLE; idx, wait_cnt, latched fields → 0.
  - host_rvalid, host_rdata, host_done, host_busy → 0.
  - host_wready=0, cpu_stall=0, mem_we=0.
- Reset mid-burst: the burst aborts immediately. No host_done pulse. Beats already written persist; the remaining addresses are untouched.
- Latency, core idle: host_go at cycle 0 → WAIT at cycle 1 → first beat at cycle 2 → DONE at cycle 2+N for N beats with no wvalid gaps.
- Read: host_rvalid for beat k occurs one cycle after that beat's address. The last host_rvalid coincides with host_done.
- Core access is zero-latency whenever granted. A stalled core access completes in the DONE cycle at the earliest.
- host_go together with reset_n=0: reset wins.

## Test plan
- Reset: reset_n=0 for 2 cycles with host_go=1 → all outputs 0, state IDLE. After release, a new host_go starts a burst normally.
- Write preload, core idle: go at cycle 0, base=0x00, len=3, data 05,55,07,FF with wvalid always high → mem_we at cycles 2–5, mem[0..3]=05 55 07 FF, host_done at cycle 6.
- Wrap and gaps: base=0xFE, len=2, data AA,BB,CC with wvalid low for 2 cycles after the first beat → mem[FE]=AA, mem[FF]=BB, mem[00]=CC. idx holds during the gap.
- Contention: cpu_req=1 continuously with a store to 0x10 during WAIT, STARVE=4 → WAIT lasts 4 cycles and the store commits. cpu_stall=1 exactly during BURST. mem_we never reflects cpu_we in BURST.
- Read readback: base=0x05, len=3, preloaded memory → host_rvalid high 4 consecutive cycles with mem[5..8] in order. host_done coincides with the 4th rvalid.
- Abort: reset_n=0 after 2 of 4 write beats → mem gets only the first 2 bytes, no host_done pulse. A subsequent burst completes correctly.
